// File: rtl/id_fetch_queue_if.sv
// +--------------------------------------------------------------------------+
// | id_fetch_queue_if : IF->ID fetch queue handshake, flush and status bundle|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface id_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic [ADDR_W-1:0] in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic              in_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus_4;
  logic              out_ready;
  logic              flush;
  logic              keep_slot;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush, keep_slot,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_plus_4, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush, keep_slot,
    output in_ready, out_valid, out_instr, out_pc, out_pc_plus_4, count
  );
endinterface

`default_nettype wire

// File: rtl/id_fetch_queue.sv
// +--------------------------------------------------------------------------+
// | id_fetch_queue : circular IF->ID instruction queue with redirect flush.  |
// | Macro ID_FETCH_QUEUE_DELAY_SLOT_EN keeps one delay-slot entry on flush.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module id_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  id_fetch_queue_if.slave fq_io
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic in_ready;
  logic out_valid;
  logic enq;
  logic deq;
  logic keep;
  logic survivor;

`ifdef ID_FETCH_QUEUE_DELAY_SLOT_EN
  assign keep = fq_io.keep_slot;
`else
  logic unused_keep_slot;
  assign unused_keep_slot = fq_io.keep_slot;
  assign keep             = 1'b0;
`endif

  // Ready comes from the registered count only, and is forced low in reset.
  assign in_ready  = !rst && (count_q < C_DEPTH);
  assign out_valid = (count_q != '0);
  assign enq       = fq_io.in_valid && in_ready;
  assign deq       = out_valid && fq_io.out_ready;

  // An entry survives a retaining flush only if one is left after this cycle's dequeue.
  assign survivor  = (count_q > (deq ? CNT_W'(1) : CNT_W'(0)));

  always_comb begin
    rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fq_io.flush) begin
      if (keep && survivor) begin
        wr_ptr_d = rd_ptr_d + PTR_W'(1);
        count_d  = CNT_W'(1);
      end else begin
        wr_ptr_d = rd_ptr_d;
        count_d  = '0;
      end
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !fq_io.flush) begin
      instr_mem_q[wr_ptr_q] <= fq_io.in_instr;
      pc_mem_q[wr_ptr_q]    <= fq_io.in_pc;
    end
  end

  assign fq_io.in_ready      = in_ready;
  assign fq_io.out_valid     = out_valid;
  assign fq_io.count         = count_q;
  assign fq_io.out_instr     = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign fq_io.out_pc        = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign fq_io.out_pc_plus_4 = out_valid ? pc_mem_q[rd_ptr_q] + ADDR_W'(4) : '0;

endmodule

`default_nettype wire
